// File: rtl/ats_flow_table.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ats_flow_table
// Purpose  : Per-flow ATS shaper parameter table. Stores bucket entries in a
//            single-port RAM, keeps per-group timing registers in flops.
// Revision : 1.0  initial release
// ============================================================================
module ats_flow_table #(
    parameter int NUM_GROUP  = 24,
    parameter int NUM_FLOW   = 16,
    parameter int TIME_WIDTH = 59,
    parameter int RD_LATENCY = 3,
    localparam int GW = $clog2(NUM_GROUP),
    localparam int FW = $clog2(NUM_FLOW)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [GW-1:0]         cmd_group,
    input  logic [FW-1:0]         cmd_flow,
    input  logic [31:0]           cmd_size,
    input  logic [31:0]           cmd_rate,
    input  logic [TIME_WIDTH-1:0] cmd_time_a,
    input  logic [TIME_WIDTH-1:0] cmd_time_b,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_bucket_size,
    output logic [31:0]           rsp_token_rate,
    output logic [TIME_WIDTH-1:0] rsp_bucket_empty_time,
    output logic [TIME_WIDTH-1:0] rsp_group_eligibility_time,
    output logic [TIME_WIDTH-1:0] rsp_max_residence_time,
    output logic                  init_done
);

    localparam int AW    = GW + FW;
    localparam int DEPTH = NUM_GROUP * NUM_FLOW;
    localparam int EW    = TIME_WIDTH + 64;

    localparam logic [AW-1:0] c_INIT_LAST  = AW'(DEPTH - 1);
    localparam logic [2:0]    c_WAIT_LAST  = 3'(RD_LATENCY - 1);
    localparam logic [GW:0]   c_NUM_GROUP  = (GW + 1)'(NUM_GROUP);
    localparam logic [1:0]    c_OP_LOOKUP  = 2'd0;
    localparam logic [1:0]    c_OP_UPDATE  = 2'd1;
    localparam logic [1:0]    c_OP_CFG_ENT = 2'd2;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_RESP     = 3'd3,
        S_RMW_WAIT = 3'd4,
        S_WRITE    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_init_cnt;
    logic [2:0]            r_wait_cnt;
    logic                  r_init_done;

    logic [1:0]            r_op;
    logic [AW-1:0]         r_addr;
    logic [31:0]           r_size;
    logic [31:0]           r_rate;
    logic [TIME_WIDTH-1:0] r_time_a;
    logic [TIME_WIDTH-1:0] r_elig_cap;
    logic [TIME_WIDTH-1:0] r_mrt_cap;
    logic [TIME_WIDTH-1:0] r_elig [NUM_GROUP];
    logic [TIME_WIDTH-1:0] r_mrt  [NUM_GROUP];

    logic [EW-1:0]         r_mem     [DEPTH];
    logic [EW-1:0]         r_rd_pipe [RD_LATENCY];
    logic [EW-1:0]         w_rd_data;

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [31:0]           r_rsp_size;
    logic [31:0]           r_rsp_rate;
    logic [TIME_WIDTH-1:0] r_rsp_empty;
    logic [TIME_WIDTH-1:0] r_rsp_elig;
    logic [TIME_WIDTH-1:0] r_rsp_mrt;

    logic                  w_accept;
    logic                  w_group_ok;
    logic                  w_ram_we;
    logic [AW-1:0]         w_ram_addr;
    logic [EW-1:0]         w_ram_wdata;
    logic                  w_rsp_load;
    logic                  w_rsp_err;
    logic                  w_rsp_lookup;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_group_ok = ({1'b0, cmd_group} < c_NUM_GROUP);
    assign w_rd_data  = r_rd_pipe[RD_LATENCY-1];

    // Command address goes straight to the RAM in IDLE so the read starts on the accept edge.
    assign w_ram_addr  = (r_state == S_INIT) ? r_init_cnt :
                         (r_state == S_IDLE) ? {cmd_group, cmd_flow} : r_addr;
    assign w_ram_we    = (r_state == S_INIT) || (r_state == S_WRITE);
    assign w_ram_wdata = (r_state == S_INIT)    ? '0 :
                         (r_op == c_OP_UPDATE)  ? {r_time_a, w_rd_data[63:0]} :
                                                  {r_time_a, r_rate, r_size};

    always_comb begin
        w_state_nxt  = r_state;
        w_rsp_load   = 1'b0;
        w_rsp_err    = 1'b0;
        w_rsp_lookup = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_init_cnt == c_INIT_LAST) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!w_group_ok) begin
                        w_state_nxt = S_RESP;
                        w_rsp_load  = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else begin
                        case (cmd_op)
                            c_OP_LOOKUP:  w_state_nxt = S_RD_WAIT;
                            c_OP_UPDATE:  w_state_nxt = S_RMW_WAIT;
                            c_OP_CFG_ENT: begin
                                w_state_nxt = S_WRITE;
                                w_rsp_load  = 1'b1;
                            end
                            default: begin
                                w_state_nxt = S_RESP;
                                w_rsp_load  = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt  = S_RESP;
                    w_rsp_load   = 1'b1;
                    w_rsp_lookup = 1'b1;
                end
            end
            S_RMW_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = S_WRITE;
                    w_rsp_load  = 1'b1;
                end
            end
            S_WRITE, S_RESP: w_state_nxt = S_IDLE;
            default:         w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
            if ((r_state == S_INIT) && (w_state_nxt == S_IDLE)) r_init_done <= 1'b1;
            if ((r_state == S_RD_WAIT) || (r_state == S_RMW_WAIT))
                r_wait_cnt <= r_wait_cnt + 3'd1;
            else
                r_wait_cnt <= '0;
        end
    end

    // Command capture and group registers; group writes land on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_addr     <= '0;
            r_size     <= '0;
            r_rate     <= '0;
            r_time_a   <= '0;
            r_elig_cap <= '0;
            r_mrt_cap  <= '0;
            for (int g = 0; g < NUM_GROUP; g++) begin
                r_elig[g] <= '0;
                r_mrt[g]  <= '0;
            end
        end else if (w_accept) begin
            r_op     <= cmd_op;
            r_addr   <= {cmd_group, cmd_flow};
            r_size   <= cmd_size;
            r_rate   <= cmd_rate;
            r_time_a <= cmd_time_a;
            if (w_group_ok) begin
                r_elig_cap <= r_elig[cmd_group];
                r_mrt_cap  <= r_mrt[cmd_group];
                if (cmd_op == c_OP_UPDATE) r_elig[cmd_group] <= cmd_time_b;
                if (cmd_op == 2'd3)        r_mrt[cmd_group]  <= cmd_time_a;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_size  <= '0;
            r_rsp_rate  <= '0;
            r_rsp_empty <= '0;
            r_rsp_elig  <= '0;
            r_rsp_mrt   <= '0;
        end else begin
            r_rsp_valid <= w_rsp_load;
            if (w_rsp_load) begin
                r_rsp_err   <= w_rsp_err;
                r_rsp_size  <= w_rsp_lookup ? w_rd_data[31:0]     : '0;
                r_rsp_rate  <= w_rsp_lookup ? w_rd_data[63:32]    : '0;
                r_rsp_empty <= w_rsp_lookup ? w_rd_data[EW-1:64]  : '0;
                r_rsp_elig  <= w_rsp_lookup ? r_elig_cap          : '0;
                r_rsp_mrt   <= w_rsp_lookup ? r_mrt_cap           : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
        r_rd_pipe[0] <= r_mem[w_ram_addr];
        for (int i = 1; i < RD_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
    end

    assign cmd_ready                  = (r_state == S_IDLE);
    assign init_done                  = r_init_done;
    assign rsp_valid                  = r_rsp_valid;
    assign rsp_err                    = r_rsp_err;
    assign rsp_bucket_size            = r_rsp_size;
    assign rsp_token_rate             = r_rsp_rate;
    assign rsp_bucket_empty_time      = r_rsp_empty;
    assign rsp_group_eligibility_time = r_rsp_elig;
    assign rsp_max_residence_time     = r_rsp_mrt;

endmodule
`default_nettype wire

// File: tb/tb_ats_flow_table.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ats_flow_table
// Purpose  : Directed self-checking bench for ats_flow_table (default params).
// Revision : 1.0  initial release
// ============================================================================
module tb_ats_flow_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_group;
    logic [3:0]  cmd_flow;
    logic [31:0] cmd_size;
    logic [31:0] cmd_rate;
    logic [58:0] cmd_time_a;
    logic [58:0] cmd_time_b;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_bucket_size;
    logic [31:0] rsp_token_rate;
    logic [58:0] rsp_bucket_empty_time;
    logic [58:0] rsp_group_eligibility_time;
    logic [58:0] rsp_max_residence_time;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ats_flow_table dut (
        .clk                        (clk),
        .reset                      (reset),
        .cmd_valid                  (cmd_valid),
        .cmd_ready                  (cmd_ready),
        .cmd_op                     (cmd_op),
        .cmd_group                  (cmd_group),
        .cmd_flow                   (cmd_flow),
        .cmd_size                   (cmd_size),
        .cmd_rate                   (cmd_rate),
        .cmd_time_a                 (cmd_time_a),
        .cmd_time_b                 (cmd_time_b),
        .rsp_valid                  (rsp_valid),
        .rsp_err                    (rsp_err),
        .rsp_bucket_size            (rsp_bucket_size),
        .rsp_token_rate             (rsp_token_rate),
        .rsp_bucket_empty_time      (rsp_bucket_empty_time),
        .rsp_group_eligibility_time (rsp_group_eligibility_time),
        .rsp_max_residence_time     (rsp_max_residence_time),
        .init_done                  (init_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command, scrambles the inputs right after acceptance, and
    // returns the number of negedges until rsp_valid is seen (50 = timeout).
    task automatic issue(input logic [1:0] op, input logic [4:0] g, input logic [3:0] f,
                         input logic [31:0] sz, input logic [31:0] rt,
                         input logic [58:0] ta, input logic [58:0] tb, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_group  = g;
        cmd_flow   = f;
        cmd_size   = sz;
        cmd_rate   = rt;
        cmd_time_a = ta;
        cmd_time_b = tb;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_group  = ~g;
        cmd_flow   = ~f;
        cmd_size   = ~sz;
        cmd_rate   = ~rt;
        cmd_time_a = ~ta;
        cmd_time_b = ~tb;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
    endtask

    // Releases reset at a negedge and returns negedges until init_done, plus
    // counts of cycles in which cmd_ready or rsp_valid were seen during INIT.
    task automatic run_init(output int cyc, output int ready_seen, output int rsp_seen);
        cyc = 0;
        ready_seen = 0;
        rsp_seen = 0;
        @(negedge clk);
        reset = 1'b0;
        while (cyc < 1000) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (init_done) break;
            if (cmd_ready) ready_seen++;
            if (rsp_valid) rsp_seen++;
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int rdy;
        int rsp;
        logic [122:0] entry;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_group  = '0;
        cmd_flow   = '0;
        cmd_size   = '0;
        cmd_rate   = '0;
        cmd_time_a = '0;
        cmd_time_b = '0;
        repeat (3) @(negedge clk);

        check("rst_init_done", init_done, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_size", rsp_bucket_size, 0);

        run_init(cyc, rdy, rsp);
        check("init_cycles", cyc, 384);
        check("init_ready_low", rdy, 0);
        check("idle_ready", cmd_ready, 1);

        // Cleared table
        issue(2'd0, 5'd5, 4'd3, 0, 0, 0, 0, lat);
        check("lk53_lat", lat, 4);
        check("lk53_err", rsp_err, 0);
        check("lk53_size", rsp_bucket_size, 0);
        check("lk53_rate", rsp_token_rate, 0);
        check("lk53_empty", rsp_bucket_empty_time, 0);
        check("lk53_elig", rsp_group_eligibility_time, 0);
        check("lk53_mrt", rsp_max_residence_time, 0);

        issue(2'd2, 5'd11, 4'd3, 32'd3200, 32'd320000, 59'd0, 59'd0, lat);
        check("cfg_lat", lat, 1);
        check("cfg_size_zero", rsp_bucket_size, 0);

        issue(2'd0, 5'd11, 4'd3, 0, 0, 0, 0, lat);
        check("lk113_lat", lat, 4);
        check("lk113_size", rsp_bucket_size, 3200);
        check("lk113_rate", rsp_token_rate, 320000);
        @(negedge clk);
        check("pulse_low", rsp_valid, 0);
        check("hold_size", rsp_bucket_size, 3200);

        issue(2'd0, 5'd11, 4'd2, 0, 0, 0, 0, lat);
        check("lk112_size", rsp_bucket_size, 0);

        issue(2'd1, 5'd11, 4'd3, 32'hFFFF, 32'hFFFF, 59'h1234, 59'h99, lat);
        check("upd_lat", lat, 4);
        check("upd_rate_zero", rsp_token_rate, 0);

        issue(2'd0, 5'd11, 4'd3, 0, 0, 0, 0, lat);
        check("rmw_size", rsp_bucket_size, 3200);
        check("rmw_rate", rsp_token_rate, 320000);
        check("rmw_empty", rsp_bucket_empty_time, 59'h1234);
        check("rmw_elig", rsp_group_eligibility_time, 59'h99);
        check("rmw_mrt", rsp_max_residence_time, 0);

        issue(2'd3, 5'd8, 4'd0, 0, 0, 59'd500, 0, lat);
        check("mrt_lat", lat, 1);
        issue(2'd0, 5'd8, 4'd0, 0, 0, 0, 0, lat);
        check("mrt8", rsp_max_residence_time, 500);
        check("elig8", rsp_group_eligibility_time, 0);
        issue(2'd0, 5'd9, 4'd0, 0, 0, 0, 0, lat);
        check("mrt9", rsp_max_residence_time, 0);

        // Out-of-range group
        issue(2'd0, 5'd24, 4'd3, 0, 0, 0, 0, lat);
        check("bad_lat", lat, 1);
        check("bad_err", rsp_err, 1);
        check("bad_size", rsp_bucket_size, 0);
        check("bad_mrt", rsp_max_residence_time, 0);
        issue(2'd2, 5'd27, 4'd3, 32'd77, 32'd77, 59'd77, 0, lat);
        check("bad_cfg_err", rsp_err, 1);
        issue(2'd0, 5'd11, 4'd3, 0, 0, 0, 0, lat);
        check("after_bad_err", rsp_err, 0);
        check("after_bad_size", rsp_bucket_size, 3200);

        // Reset in the middle of a read-modify-write
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = 2'd1;
        cmd_group  = 5'd11;
        cmd_flow   = 4'd3;
        cmd_time_a = 59'h5555;
        cmd_time_b = 59'h66;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_ready", cmd_ready, 0);
        check("abort_init_done", init_done, 0);
        entry = dut.r_mem[179];
        check("abort_mem_size", entry[31:0], 3200);
        check("abort_mem_empty", entry[122:64], 59'h1234);
        repeat (4) @(negedge clk);
        check("abort_rsp_hold", rsp_valid, 0);

        run_init(cyc, rdy, rsp);
        check("reinit_cycles", cyc, 384);
        check("reinit_ready_low", rdy, 0);
        check("reinit_no_rsp", rsp, 0);

        issue(2'd0, 5'd11, 4'd3, 0, 0, 0, 0, lat);
        check("cleared_lat", lat, 4);
        check("cleared_size", rsp_bucket_size, 0);
        check("cleared_empty", rsp_bucket_empty_time, 0);
        check("cleared_elig", rsp_group_eligibility_time, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ats_flow_table.md
ATS_FLOW_TABLE -- requirements
Module: ats_flow_table

Interface
REQ-001 SHALL have parameter NUM_GROUP, default 24, number of groups; GW = clog2(NUM_GROUP).
REQ-002 SHALL have parameter NUM_FLOW, default 16, flows per group (power of two); FW = log2(NUM_FLOW).
REQ-003 SHALL have parameter TIME_WIDTH, default 59, width of all time fields.
REQ-004 SHALL have parameter RD_LATENCY, default 3, internal RAM read latency in cycles (1..8).
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  command present.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at a clk edge.
REQ-009 SHALL have port cmd_op  input  2  0=lookup, 1=update, 2=cfg_entry, 3=cfg_mrt.
REQ-010 SHALL have port cmd_group  input  GW  group index.
REQ-011 SHALL have port cmd_flow  input  FW  flow index in group.
REQ-012 SHALL have port cmd_size  input  32  bucket size (cfg_entry).
REQ-013 SHALL have port cmd_rate  input  32  token rate (cfg_entry).
REQ-014 SHALL have port cmd_time_a  input  TIME_WIDTH  bucket empty time (update, cfg_entry), or max residence time (cfg_mrt).
REQ-015 SHALL have port cmd_time_b  input  TIME_WIDTH  group eligibility time (update).
REQ-016 SHALL have port rsp_valid  output  1  one-cycle response pulse, exactly one per accepted command.
REQ-017 SHALL have port rsp_err  output  1  out-of-range group, qualified by rsp_valid.
REQ-018 SHALL have ports rsp_bucket_size and rsp_token_rate  output  32 each  lookup results.
REQ-019 SHALL have ports rsp_bucket_empty_time, rsp_group_eligibility_time and rsp_max_residence_time  output  TIME_WIDTH each  lookup results.
REQ-020 SHALL have port init_done  output  1  table clear complete.

Function
REQ-021 SHALL hold NUM_GROUP*NUM_FLOW entries in an internal single-port RAM.
- Address {group, flow}.
- Entry {empty_time[TIME_WIDTH], rate[32], size[32]}.
- Per-group max-residence and eligibility registers in flops.
REQ-022 SHALL implement FSM with states INIT, IDLE, RD_WAIT, RESP, RMW_WAIT, WRITE.
REQ-023 INIT SHALL write zero to addresses 0..NUM_GROUP*NUM_FLOW-1, one per cycle, then set init_done=1 and go to IDLE; cmd_ready=0 throughout.
REQ-024 cmd_ready SHALL be 1 only in IDLE; it drops the cycle after acceptance and returns to 1 when the FSM re-enters IDLE.
REQ-025 Lookup accepted at edge T SHALL:
- drive the RAM address at T;
- wait RD_LATENCY cycles in RD_WAIT;
- pulse rsp_valid in cycle T+RD_LATENCY+1 with RAM fields and both group registers of cmd_group captured at T.
REQ-026 Update SHALL be a true read-modify-write:
- read entry (RMW_WAIT, RD_LATENCY cycles);
- WRITE {cmd_time_a, old rate, old size};
- write eligibility[group]=cmd_time_b at acceptance;
- rsp_valid in the WRITE cycle, data fields zero.
REQ-027 cfg_entry SHALL write {cmd_time_a, cmd_rate, cmd_size} in WRITE one cycle after accept, with rsp_valid in the same cycle and data fields zero.
REQ-028 cfg_mrt SHALL write max_residence[group]=cmd_time_a at acceptance, with no RAM access, and pulse rsp_valid the next cycle with data fields zero.
REQ-029 cmd_group >= NUM_GROUP SHALL perform no RAM or register write and pulse rsp_valid with rsp_err=1 and all data zero one cycle after accept, for any op.
REQ-030 Command fields SHALL be registered at acceptance; input changes afterwards SHALL not affect the operation.
REQ-031 rsp_* data SHALL hold their last values when rsp_valid=0.

Reset
REQ-032 Reset SHALL force the following values:
- FSM=INIT, init_done=0, cmd_ready=0, rsp_valid=0, rsp_err=0;
- all rsp data=0;
- all group registers=0;
- INIT counter=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no response, and INIT SHALL restart from address 0 after deassertion.

Verification
REQ-034 Reset, count cycles -> init_done rises after exactly NUM_GROUP*NUM_FLOW INIT cycles (384 default); a lookup of (5,3) returns all zeros, rsp_err=0.
REQ-035 cfg_entry (11,3) size=3200 rate=320000 time_a=0, then lookup (11,3) -> rsp_valid exactly RD_LATENCY+1 cycles after accept; size=3200, rate=320000.
REQ-036 After REQ-035, update (11,3) time_a=0x1234 time_b=0x99, then lookup -> size=3200, rate=320000, empty_time=0x1234, eligibility=0x99.
REQ-037 cfg_mrt group 8 = 500; lookup (8,0) -> max_residence=500; lookup (9,0) -> 0.
REQ-038 Lookup with group 24 (NUM_GROUP=24) -> rsp_valid with rsp_err=1 one cycle after accept, data zero; RAM unchanged.
REQ-039 Assert reset during RMW_WAIT of an update -> no rsp_valid; entry unchanged until INIT clears it; cmd_ready stays 0 until init_done.
